// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding and default sizing for the timer interrupt controller
package tc_pkg;
    localparam int TC_NSRC = 6;
    localparam logic [5:0] TC_VEC_BASE = 6'h07;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CLR  = 2'd2,
        ST_HOLD = 2'd3
    } tc_state_e;
endpackage

// File: rtl/tc_int_ctrl_if.sv
// tc_int_ctrl_if: timer/CPU side signals of the interrupt controller
interface tc_int_ctrl_if #(parameter int NSRC = tc_pkg::TC_NSRC);
    logic [NSRC-1:0] pend;
    logic            status_reg_interrupt_enable;
    logic            interrupt_executed;
    logic            interrupt_request;
    logic [5:0]      vector;
    logic [NSRC-1:0] flag_clr;
    logic            busy;
    modport master (
        output pend, status_reg_interrupt_enable, interrupt_executed,
        input  interrupt_request, vector, flag_clr, busy
    );
    modport slave (
        input  pend, status_reg_interrupt_enable, interrupt_executed,
        output interrupt_request, vector, flag_clr, busy
    );
endinterface

// File: rtl/tc_prio_enc.sv
// tc_prio_enc: lowest-index-wins priority encoder over the pending flags
module tc_prio_enc #(
    parameter int NSRC = 6,
    parameter int SW   = 3
) (
    input  logic [NSRC-1:0] pend,
    output logic [SW-1:0]   idx,
    output logic            valid
);
    always_comb begin
        idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (pend[i]) idx = SW'(i);
    end
    assign valid = |pend;
endmodule

// File: rtl/tc_int_ctrl.sv
// tc_int_ctrl: arbitrates timer interrupt flags into a single registered CPU request
module tc_int_ctrl
    import tc_pkg::*;
#(
    parameter int         NSRC     = TC_NSRC,
    parameter logic [5:0] VEC_BASE = TC_VEC_BASE
) (
    input  logic          clk,
    input  logic          rst,
    tc_int_ctrl_if.slave  bus
);
    localparam int SW = NSRC > 1 ? $clog2(NSRC) : 1;
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] REQ  = ST_REQ;
    localparam logic [1:0] CLR  = ST_CLR;
    localparam logic [1:0] HOLD = ST_HOLD;

    logic [1:0]    state, nxt;
    logic [SW-1:0] sel, sel_nxt, idx;
    logic          valid;

    tc_prio_enc #(.NSRC(NSRC), .SW(SW)) u_enc (
        .pend  (bus.pend),
        .idx   (idx),
        .valid (valid)
    );

    // acknowledge wins over withdrawal; sel is frozen once the request is raised
    always_comb begin
        nxt = state == IDLE ? ((bus.status_reg_interrupt_enable && valid) ? REQ : IDLE)
            : state == REQ  ? (bus.interrupt_executed ? CLR
                              : (!bus.pend[sel] || !bus.status_reg_interrupt_enable) ? IDLE : REQ)
            : state == CLR  ? HOLD
            : IDLE;
        sel_nxt = (state == IDLE && nxt == REQ) ? idx : sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            sel                   <= '0;
            bus.interrupt_request <= 1'b0;
            bus.vector            <= '0;
            bus.flag_clr          <= '0;
            bus.busy              <= 1'b0;
        end else begin
            state                 <= nxt;
            sel                   <= sel_nxt;
            bus.interrupt_request <= nxt == REQ;
            bus.vector            <= nxt == REQ ? VEC_BASE + 6'(sel_nxt) : '0;
            bus.flag_clr          <= nxt == CLR ? {{(NSRC-1){1'b0}}, 1'b1} << sel : '0;
            bus.busy              <= nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_tc_int_ctrl.sv
// tb_tc_int_ctrl: directed table, reset sequence and randomized model comparison
module tb_tc_int_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    tc_int_ctrl_if #(.NSRC(6)) bus ();

    tc_int_ctrl #(.NSRC(6), .VEC_BASE(6'h07)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] pend;
        logic       ie;
        logic       ex;
        logic       req;
        logic [5:0] vec;
        logic [5:0] clr;
        logic       busy;
    } vec_t;

    vec_t tv[22];

    logic       m_req;
    int         m_sel;
    int         m_cool;
    logic [5:0] m_clr;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] p, input logic i, input logic e);
        bus.pend = p;
        bus.status_reg_interrupt_enable = i;
        bus.interrupt_executed = e;
    endtask

    // request / cool-down abstraction: cool counts the clear and hold cycles left
    task automatic model_step(input logic [5:0] p, input logic i, input logic e);
        logic [5:0] lsb;
        m_clr = '0;
        if (m_req) begin
            if (e) begin
                m_req  = 1'b0;
                m_clr  = 6'(1 << m_sel);
                m_cool = 2;
            end else if (!p[m_sel] || !i) m_req = 1'b0;
        end else if (m_cool > 0) m_cool--;
        else if (i && p != 0) begin
            lsb   = p & (~p + 6'd1);
            m_sel = $clog2(lsb);
            m_req = 1'b1;
        end
    endtask

    initial begin
        tv[0]  = '{6'b000100, 1'b1, 1'b0, 1'b1, 6'h09, 6'b000000, 1'b1};
        tv[1]  = '{6'b000100, 1'b1, 1'b1, 1'b0, 6'h00, 6'b000100, 1'b1};
        tv[2]  = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1};
        tv[3]  = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[4]  = '{6'b100000, 1'b1, 1'b0, 1'b1, 6'h0C, 6'b000000, 1'b1};
        tv[5]  = '{6'b100001, 1'b1, 1'b0, 1'b1, 6'h0C, 6'b000000, 1'b1};
        tv[6]  = '{6'b100001, 1'b1, 1'b1, 1'b0, 6'h00, 6'b100000, 1'b1};
        tv[7]  = '{6'b000001, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1};
        tv[8]  = '{6'b000001, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[9]  = '{6'b000001, 1'b1, 1'b0, 1'b1, 6'h07, 6'b000000, 1'b1};
        tv[10] = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[11] = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[12] = '{6'b000001, 1'b0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[13] = '{6'b000001, 1'b0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[14] = '{6'b000001, 1'b1, 1'b0, 1'b1, 6'h07, 6'b000000, 1'b1};
        tv[15] = '{6'b000000, 1'b1, 1'b1, 1'b0, 6'h00, 6'b000001, 1'b1};
        tv[16] = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b1};
        tv[17] = '{6'b000000, 1'b1, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[18] = '{6'b000000, 1'b1, 1'b1, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[19] = '{6'b010000, 1'b1, 1'b0, 1'b1, 6'h0B, 6'b000000, 1'b1};
        tv[20] = '{6'b010000, 1'b0, 1'b0, 1'b0, 6'h00, 6'b000000, 1'b0};
        tv[21] = '{6'b010000, 1'b0, 1'b1, 1'b0, 6'h00, 6'b000000, 1'b0};

        drive(6'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.interrupt_request), 32'd0);
        check("rst_vec", 32'(bus.vector), 32'd0);
        check("rst_clr", 32'(bus.flag_clr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;

        for (int k = 0; k < 22; k++) begin
            drive(tv[k].pend, tv[k].ie, tv[k].ex);
            @(negedge clk);
            check($sformatf("tbl%0d_req", k), 32'(bus.interrupt_request), 32'(tv[k].req));
            if (tv[k].req) check($sformatf("tbl%0d_vec", k), 32'(bus.vector), 32'(tv[k].vec));
            check($sformatf("tbl%0d_clr", k), 32'(bus.flag_clr), 32'(tv[k].clr));
            check($sformatf("tbl%0d_busy", k), 32'(bus.busy), 32'(tv[k].busy));
        end

        drive(6'b000010, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_req", 32'(bus.interrupt_request), 32'd1);
        check("pre_rst_vec", 32'(bus.vector), 32'h08);
        #2 rst = 1'b0;
        #1;
        check("async_req", 32'(bus.interrupt_request), 32'd0);
        check("async_vec", 32'(bus.vector), 32'd0);
        check("async_clr", 32'(bus.flag_clr), 32'd0);
        check("async_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("in_rst_clr", 32'(bus.flag_clr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("reissue_req", 32'(bus.interrupt_request), 32'd1);
        check("reissue_vec", 32'(bus.vector), 32'h08);
        check("reissue_clr", 32'(bus.flag_clr), 32'd0);

        drive(6'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_req = 1'b0;
        m_sel = 0;
        m_cool = 0;
        m_clr = '0;
        for (int n = 0; n < 400; n++) begin
            logic [5:0] p;
            for (int b = 0; b < 6; b++) p[b] = ($urandom_range(0, 9) < 3);
            drive(p, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            model_step(bus.pend, bus.status_reg_interrupt_enable, bus.interrupt_executed);
            @(negedge clk);
            check($sformatf("rnd%0d_req", n), 32'(bus.interrupt_request), 32'(m_req));
            if (m_req) check($sformatf("rnd%0d_vec", n), 32'(bus.vector), 32'(6'(7 + m_sel)));
            check($sformatf("rnd%0d_clr", n), 32'(bus.flag_clr), 32'(m_clr));
            check($sformatf("rnd%0d_busy", n), 32'(bus.busy), 32'(m_req || m_cool > 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
